dcmi_frame_scheduler: RTL and testbench
=======================================

Name: dcmi_frame_scheduler

Overview:
- Sequences the team's DCMI frame transmitter (8-bit frame RAM with write/reset API and START trigger) and shares it between two frame requesters.
- Grants the loading port to one requester at a time using round-robin, forwards its bytes, and fires START.
- Tracks DSYNC to frame completion, then enforces an inter-frame gap.
- Sits between the MCU-side/packet sources and the transmitter.

Parameters:
- LEN_BITS, 10: transmitter RAM address width. Max bytes per frame = (1<<LEN_BITS)-1.
- GAP_CYCLES, 16: idle Clk cycles after each frame before the next grant (≥1).
- TIMEOUT_BITS, 16: DSYNC watchdog width. Limit = (1<<TIMEOUT_BITS)-1 cycles per wait state.

Ports:
- Clk  in  1  global clock
- RST  in  1  synchronous active-high reset
- REQ0/REQ1  in  1  requester wants a frame slot; hold high until FRAME_DONE
- GNT0/GNT1  out  1  requester may write bytes
- DI0/DI1  in  8  requester byte
- WR0/WR1  in  1  byte strobe; ignored unless matching GNT=1
- LAST0/LAST1  in  1  qualifies final byte; meaningful only with WR
- TX_DI  out  8  to transmitter DI
- TX_WR  out  1  to transmitter WR
- TX_RST  out  1  to transmitter write-pointer reset
- TX_START  out  1  to transmitter START
- TX_DSYNC  in  1  from transmitter DSYNC
- BUSY  out  1  state != IDLE
- FRAME_DONE  out  1  one-cycle completion pulse
- FRAME_SRC  out  1  requester index of the finished frame; valid with FRAME_DONE
- FRAME_LEN  out  LEN_BITS  bytes forwarded; valid with FRAME_DONE
- ERR_CODE  out  3  0 ok, 1 truncated, 2 rise timeout, 3 fall timeout, 4 aborted; valid with FRAME_DONE

Behaviour:
- Reset (synchronous, checked every cycle, overrides all): state = IDLE; all outputs 0; byte count 0; watchdog 0; last_src = 1. Reset mid-frame is abandoned silently, with no FRAME_DONE. The next frame's CLEAR resets the transmitter pointer.
- All outputs are registered.
- States: IDLE → CLEAR → LOAD → FLUSH → START → WAIT_RISE → WAIT_FALL → GAP → IDLE.
- IDLE:
  - Sample REQ0/REQ1.
  - One requester high: select it.
  - Both high: select !last_src, so after reset REQ0 wins the first tie.
  - Latch src, go to CLEAR.
- CLEAR (1 cycle): TX_RST = 1; count = 0.
- LOAD:
  - GNTsrc = 1.
  - On WRsrc: TX_DI <= DIsrc and TX_WR <= 1 (1-cycle latency); count++.
  - If count == max, the byte is dropped, no TX_WR is issued, and a sticky trunc flag is set.
  - WRsrc & LASTsrc: forward the byte if room remains; GNT drops next cycle; go to FLUSH.
  - REQsrc low before LAST: GNT drops, ERR_CODE 4, FRAME_DONE pulses with FRAME_LEN = count, no TX_START, go to GAP.
- FLUSH (1 cycle): lets the final TX_WR land before START. TX_START must never coincide with TX_WR.
- START (1 cycle): TX_START = 1; watchdog cleared; go to WAIT_RISE.
- WAIT_RISE:
  - TX_DSYNC = 1: go to WAIT_FALL with watchdog cleared.
  - Watchdog reaches limit: FRAME_DONE with code 2, go to GAP.
- WAIT_FALL:
  - TX_DSYNC = 0: FRAME_DONE with code 1 if trunc, else 0.
  - Watchdog reaches limit: FRAME_DONE with code 3.
  - Either way, go to GAP.
- GAP: count GAP_CYCLES; last_src <= src; go to IDLE. No grant is issued during GAP.
- FRAME_SRC/FRAME_LEN/ERR_CODE hold their value until the next FRAME_DONE.
- Requests arriving at any time are only evaluated in IDLE, so a REQ held through GAP is served next.

Test Plan:
- Reset, REQ0 only, write 4 bytes 0xA1..0xA4 (LAST on 0xA4), TX_DSYNC high 5 cycles after TX_START → TX_RST one cycle before GNT0; TX_WR ×4 with data 0xA1..0xA4, each 1 cycle after its WR0; TX_START exactly 2 cycles after the LAST write; FRAME_DONE on the DSYNC fall with SRC=0, LEN=4, ERR=0.
- REQ0 and REQ1 held continuously for 3 frames → grant order 0,1,0; ≥GAP_CYCLES idle between FRAME_DONE and next GNT.
- LEN_BITS=4, write 20 bytes → exactly 15 TX_WR; FRAME_LEN=15; ERR=1.
- TIMEOUT_BITS=4, TX_DSYNC stuck 0 → FRAME_DONE 15 cycles after WAIT_RISE entry, ERR=2. Same test with DSYNC stuck 1 → ERR=3.
- REQ1 dropped after 2 bytes, no LAST → ERR=4, LEN=2, no TX_START pulse, then back to IDLE after the gap.
- RST asserted in WAIT_FALL → next cycle all outputs 0, BUSY=0, no FRAME_DONE. A subsequent REQ1 is granted, and a tie then goes to REQ0.

Source files
------------

// File: rtl/dcmi_frame_scheduler.sv
// Round-robin front end for the DCMI frame transmitter: grants one requester the
// load port, forwards its bytes, fires START, then tracks DSYNC and spaces frames.
module dcmi_frame_scheduler #(
  parameter int LEN_BITS     = 10,
  parameter int GAP_CYCLES   = 16,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic                Clk,
  input  logic                RST,
  input  logic                REQ0,
  input  logic                REQ1,
  output logic                GNT0,
  output logic                GNT1,
  input  logic [7:0]          DI0,
  input  logic [7:0]          DI1,
  input  logic                WR0,
  input  logic                WR1,
  input  logic                LAST0,
  input  logic                LAST1,
  output logic [7:0]          TX_DI,
  output logic                TX_WR,
  output logic                TX_RST,
  output logic                TX_START,
  input  logic                TX_DSYNC,
  output logic                BUSY,
  output logic                FRAME_DONE,
  output logic                FRAME_SRC,
  output logic [LEN_BITS-1:0] FRAME_LEN,
  output logic [2:0]          ERR_CODE
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_FLUSH, S_START, S_WAIT_RISE, S_WAIT_FALL, S_GAP
  } state_t;

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]           GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [LEN_BITS-1:0]     LEN_MAX  = '1;
  // Watchdog fires when the incremented value would equal the all-ones limit.
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST  = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  localparam logic [2:0] ERR_OK    = 3'd0;
  localparam logic [2:0] ERR_TRUNC = 3'd1;
  localparam logic [2:0] ERR_RISE  = 3'd2;
  localparam logic [2:0] ERR_FALL  = 3'd3;
  localparam logic [2:0] ERR_ABORT = 3'd4;

  state_t                    state_q, state_d;
  logic                      src_q, src_d;
  logic                      last_src_q, last_src_d;
  logic [LEN_BITS-1:0]       count_q, count_d;
  logic                      trunc_q, trunc_d;
  logic [TIMEOUT_BITS-1:0]   wd_q, wd_d;
  logic [GW-1:0]             gap_q, gap_d;
  logic                      gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic [7:0]                tx_di_q, tx_di_d;
  logic                      tx_wr_q, tx_wr_d;
  logic                      tx_rst_q, tx_rst_d;
  logic                      tx_start_q, tx_start_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      fsrc_q, fsrc_d;
  logic [LEN_BITS-1:0]       flen_q, flen_d;
  logic [2:0]                err_q, err_d;

  logic       req_s, gnt_s, wr_s, last_s;
  logic [7:0] di_s;

  function automatic logic pick_src(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return !last;
    return r1;
  endfunction

  assign req_s  = src_q ? REQ1  : REQ0;
  assign gnt_s  = src_q ? gnt1_q : gnt0_q;
  assign wr_s   = (src_q ? WR1  : WR0) & gnt_s;
  assign last_s = src_q ? LAST1 : LAST0;
  assign di_s   = src_q ? DI1   : DI0;

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q    <= S_IDLE;
      src_q      <= 1'b0;
      last_src_q <= 1'b1;
      count_q    <= '0;
      trunc_q    <= 1'b0;
      wd_q       <= '0;
      gap_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      tx_di_q    <= '0;
      tx_wr_q    <= 1'b0;
      tx_rst_q   <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fsrc_q     <= 1'b0;
      flen_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      last_src_q <= last_src_d;
      count_q    <= count_d;
      trunc_q    <= trunc_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      tx_di_q    <= tx_di_d;
      tx_wr_q    <= tx_wr_d;
      tx_rst_q   <= tx_rst_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fsrc_q     <= fsrc_d;
      flen_q     <= flen_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    last_src_d = last_src_q;
    count_d    = count_q;
    trunc_d    = trunc_q;
    wd_d       = '0;
    gap_d      = '0;
    tx_di_d    = tx_di_q;
    tx_wr_d    = 1'b0;
    done_d     = 1'b0;
    fsrc_d     = fsrc_q;
    flen_d     = flen_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          src_d   = pick_src(REQ0, REQ1, last_src_q);
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        count_d = '0;
        trunc_d = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (wr_s) begin
          if (count_q != LEN_MAX) begin
            tx_wr_d = 1'b1;
            tx_di_d = di_s;
            count_d = count_q + 1'b1;
          end else begin
            trunc_d = 1'b1;
          end
        end
        if (wr_s && last_s) begin
          state_d = S_FLUSH;
        end else if (!req_s) begin
          // Requester walked away mid-frame: report what was forwarded, skip START.
          done_d  = 1'b1;
          fsrc_d  = src_q;
          flen_d  = count_d;
          err_d   = ERR_ABORT;
          state_d = S_GAP;
        end
      end
      S_FLUSH: state_d = S_START;
      S_START: state_d = S_WAIT_RISE;
      S_WAIT_RISE: begin
        wd_d = wd_q + 1'b1;
        if (TX_DSYNC) begin
          wd_d    = '0;
          state_d = S_WAIT_FALL;
        end else if (wd_q == WD_LAST) begin
          done_d  = 1'b1;
          fsrc_d  = src_q;
          flen_d  = count_q;
          err_d   = ERR_RISE;
          state_d = S_GAP;
        end
      end
      S_WAIT_FALL: begin
        wd_d = wd_q + 1'b1;
        if (!TX_DSYNC || (wd_q == WD_LAST)) begin
          done_d  = 1'b1;
          fsrc_d  = src_q;
          flen_d  = count_q;
          err_d   = !TX_DSYNC ? (trunc_q ? ERR_TRUNC : ERR_OK) : ERR_FALL;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST) begin
          last_src_d = src_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobe-style outputs follow the upcoming state so they line up with it.
  always_comb begin
    gnt0_d     = (state_d == S_LOAD) && !src_d;
    gnt1_d     = (state_d == S_LOAD) &&  src_d;
    tx_rst_d   = (state_d == S_CLEAR);
    tx_start_d = (state_d == S_START);
    busy_d     = (state_d != S_IDLE);
  end

  assign GNT0       = gnt0_q;
  assign GNT1       = gnt1_q;
  assign TX_DI      = tx_di_q;
  assign TX_WR      = tx_wr_q;
  assign TX_RST     = tx_rst_q;
  assign TX_START   = tx_start_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;
  assign FRAME_SRC  = fsrc_q;
  assign FRAME_LEN  = flen_q;
  assign ERR_CODE   = err_q;

endmodule

// File: tb/tb_dcmi_frame_scheduler.sv
// Directed bench for dcmi_frame_scheduler with small LEN/TIMEOUT/GAP settings.
module tb_dcmi_frame_scheduler;
  localparam int LB = 4;
  localparam int GC = 6;
  localparam int TB = 4;

  logic          Clk = 1'b0;
  logic          RST, REQ0, REQ1, WR0, WR1, LAST0, LAST1, TX_DSYNC;
  logic [7:0]    DI0, DI1;
  logic          GNT0, GNT1, TX_WR, TX_RST, TX_START, BUSY, FRAME_DONE, FRAME_SRC;
  logic [7:0]    TX_DI;
  logic [LB-1:0] FRAME_LEN;
  logic [2:0]    ERR_CODE;

  int checks = 0, errors = 0, cyc = 0, wr_seen = 0, start_seen = 0, overlap = 0, done_cyc = 0;
  int t0 = 0;

  dcmi_frame_scheduler #(.LEN_BITS(LB), .GAP_CYCLES(GC), .TIMEOUT_BITS(TB)) dut (
    .Clk(Clk), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .GNT0(GNT0), .GNT1(GNT1),
    .DI0(DI0), .DI1(DI1), .WR0(WR0), .WR1(WR1), .LAST0(LAST0), .LAST1(LAST1),
    .TX_DI(TX_DI), .TX_WR(TX_WR), .TX_RST(TX_RST), .TX_START(TX_START),
    .TX_DSYNC(TX_DSYNC), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .FRAME_SRC(FRAME_SRC),
    .FRAME_LEN(FRAME_LEN), .ERR_CODE(ERR_CODE)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
    if (TX_WR === 1'b1) wr_seen++;
    if (TX_START === 1'b1) start_seen++;
    if (TX_WR === 1'b1 && TX_START === 1'b1) overlap++;
  endtask

  task automatic drive(input logic s, input logic [7:0] d, input logic w, input logic l);
    if (s) begin DI1 = d; WR1 = w; LAST1 = l; end
    else   begin DI0 = d; WR0 = w; LAST0 = l; end
  endtask

  task automatic wait_idle(input string tag, input int exp_n);
    int n = 0;
    while (BUSY === 1'b1 && n < 60) begin step(); n++; end
    check(tag, n, exp_n);
  endtask

  task automatic wait_gnt(input logic s, input logic chk_gap);
    int t = 0;
    while (GNT0 !== 1'b1 && GNT1 !== 1'b1 && t < 40) begin step(); t++; end
    check("gnt_sel", {GNT1, GNT0}, s ? 2'b10 : 2'b01);
    if (chk_gap) check("done_to_gnt", cyc - done_cyc, GC + 2);
  endtask

  task automatic load_bytes(input logic s, input int n, input logic chk_gap);
    int t = 0;
    logic [7:0] d;
    wait_gnt(s, chk_gap);
    for (int i = 0; i < n; i++) begin
      d = 8'h30 + 8'(i);
      drive(s, d, 1'b1, i == n - 1);
      step();
    end
    drive(s, 8'h00, 1'b0, 1'b0);
    while (TX_START !== 1'b1 && t < 10) begin step(); t++; end
    check("start_seen", TX_START, 1);
  endtask

  task automatic do_frame(input logic s, input int n, input logic chk_gap);
    int t = 0;
    load_bytes(s, n, chk_gap);
    TX_DSYNC = 1'b1;
    step();
    step();
    TX_DSYNC = 1'b0;
    while (FRAME_DONE !== 1'b1 && t < 10) begin step(); t++; end
    check("frame_done", FRAME_DONE, 1);
    check("frame_src", FRAME_SRC, s);
    done_cyc = cyc;
  endtask

  task automatic wait_done(input int bound);
    int t = 0;
    while (FRAME_DONE !== 1'b1 && t < bound) begin step(); t++; end
    check("wait_done", FRAME_DONE, 1);
  endtask

  initial begin
    RST = 1'b1; REQ0 = 0; REQ1 = 0; DI0 = 0; DI1 = 0; WR0 = 0; WR1 = 0;
    LAST0 = 0; LAST1 = 0; TX_DSYNC = 0;
    step();
    step();
    check("rst_gnt", {GNT1, GNT0}, 0);
    check("rst_tx", {TX_WR, TX_RST, TX_START}, 0);
    check("rst_busy_done", {BUSY, FRAME_DONE, FRAME_SRC}, 0);
    check("rst_len_err", {FRAME_LEN, ERR_CODE}, 0);

    // Single frame from requester 0, 0xA1..0xA4
    RST = 1'b0; REQ0 = 1'b1;
    step();
    check("t1_txrst", TX_RST, 1);
    check("t1_nognt_clear", GNT0, 0);
    check("t1_busy", BUSY, 1);
    step();
    check("t1_gnt0", {GNT1, GNT0}, 2'b01);
    check("t1_txrst_off", TX_RST, 0);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'hA1 + 8'(i);
      drive(1'b0, d, 1'b1, i == 3);
      step();
      check("t1_txwr", TX_WR, 1);
      check("t1_txdi", TX_DI, d);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("t1_gnt_drop", GNT0, 0);
    check("t1_flush_nostart", TX_START, 0);
    step();
    check("t1_start", TX_START, 1);
    check("t1_start_nowr", TX_WR, 0);
    repeat (5) step();
    TX_DSYNC = 1'b1;
    step(); step(); step();
    TX_DSYNC = 1'b0;
    check("t1_no_early_done", FRAME_DONE, 0);
    step();
    check("t1_done", FRAME_DONE, 1);
    check("t1_src", FRAME_SRC, 0);
    check("t1_len", FRAME_LEN, 4);
    check("t1_err", ERR_CODE, 0);
    REQ0 = 1'b0;
    wait_idle("t1_gap", GC);
    check("t1_len_hold", FRAME_LEN, 4);
    check("t1_done_pulse", FRAME_DONE, 0);

    // Round robin with both requests held
    RST = 1'b1; step(); RST = 1'b0;
    REQ0 = 1'b1; REQ1 = 1'b1;
    do_frame(1'b0, 3, 1'b0);
    check("t2_len_a", FRAME_LEN, 3);
    do_frame(1'b1, 2, 1'b1);
    check("t2_len_b", FRAME_LEN, 2);
    do_frame(1'b0, 1, 1'b1);
    REQ0 = 1'b0; REQ1 = 1'b0;
    wait_idle("t2_idle", GC);

    // Truncation: 20 bytes into a 15-byte frame
    wr_seen = 0;
    REQ0 = 1'b1;
    do_frame(1'b0, 20, 1'b0);
    REQ0 = 1'b0;
    check("t3_wr_count", wr_seen, 15);
    check("t3_len", FRAME_LEN, 15);
    check("t3_err", ERR_CODE, 1);
    wait_idle("t3_idle", GC);

    // DSYNC never rises
    REQ1 = 1'b1;
    load_bytes(1'b1, 1, 1'b0);
    t0 = cyc;
    wait_done(40);
    check("t4_rise_lat", cyc - t0, 16);
    check("t4_rise_err", ERR_CODE, 2);
    check("t4_rise_src", FRAME_SRC, 1);
    check("t4_rise_len", FRAME_LEN, 1);
    REQ1 = 1'b0;
    wait_idle("t4_idle_a", GC);

    // DSYNC never falls
    REQ0 = 1'b1;
    load_bytes(1'b0, 1, 1'b0);
    TX_DSYNC = 1'b1;
    t0 = cyc;
    wait_done(40);
    check("t4_fall_lat", cyc - t0, 17);
    check("t4_fall_err", ERR_CODE, 3);
    check("t4_fall_src", FRAME_SRC, 0);
    TX_DSYNC = 1'b0; REQ0 = 1'b0;
    wait_idle("t4_idle_b", GC);

    // Requester 1 aborts after two bytes
    start_seen = 0;
    REQ1 = 1'b1;
    wait_gnt(1'b1, 1'b0);
    drive(1'b1, 8'h55, 1'b1, 1'b0); step();
    drive(1'b1, 8'h66, 1'b1, 1'b0); step();
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    REQ1 = 1'b0;
    step();
    check("t5_done", FRAME_DONE, 1);
    check("t5_err", ERR_CODE, 4);
    check("t5_len", FRAME_LEN, 2);
    check("t5_src", FRAME_SRC, 1);
    check("t5_gnt_drop", GNT1, 0);
    wait_idle("t5_gap", GC);
    check("t5_no_start", start_seen, 0);

    // Reset while waiting for DSYNC to fall
    REQ0 = 1'b1;
    load_bytes(1'b0, 1, 1'b0);
    TX_DSYNC = 1'b1;
    step(); step();
    check("t6_busy_pre", BUSY, 1);
    RST = 1'b1;
    step();
    check("t6_rst_busy_done", {BUSY, FRAME_DONE, FRAME_SRC}, 0);
    check("t6_rst_tx", {TX_WR, TX_RST, TX_START, GNT1, GNT0}, 0);
    check("t6_rst_data", {TX_DI, FRAME_LEN, ERR_CODE}, 0);
    RST = 1'b0; TX_DSYNC = 1'b0; REQ0 = 1'b0;
    step();
    check("t6_no_done", FRAME_DONE, 0);
    check("t6_idle", BUSY, 0);
    REQ1 = 1'b1;
    do_frame(1'b1, 2, 1'b0);
    REQ0 = 1'b1;
    do_frame(1'b0, 1, 1'b1);
    REQ0 = 1'b0; REQ1 = 1'b0;
    wait_idle("t6_idle_end", GC);

    check("start_wr_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
